// File: rtl/seq_pkg.sv
// Shared state type and program start-address table for program_sequencer.
// SEQ_TIMEOUT_EN adds the ERR state entered by the RUN watchdog.
package seq_pkg;

    localparam int unsigned SEQ_NUM_PROGS = 3;
    localparam int unsigned PROG_BASE [SEQ_NUM_PROGS] = '{0, 128, 256};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3
`ifdef SEQ_TIMEOUT_EN
        ,
        ERR    = 3'd4
`endif
    } seq_state_e;

    // Programs beyond the table continue the 128-word stride.
    function automatic int unsigned prog_base(input int unsigned idx);
        if (idx < SEQ_NUM_PROGS) begin
            return PROG_BASE[idx];
        end
        return idx * 128;
    endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Saturating RUN-cycle counter with a compare against the watchdog limit.
// limit_hit flags the cycle whose count (including itself) reaches LIMIT.
module seq_cycle_counter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LIMIT = 60000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count_next,
    output logic             limit_hit
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] count_q;

    assign count_next = (count_q == MAX) ? MAX : count_q + CNT_W'(1);
    assign limit_hit  = (32'(count_next) == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Runs programs 0..NUM_PROGS-1 back-to-back on the core via its Start/Ack handshake.
// Define SEQ_TIMEOUT_EN to enable the RUN watchdog and the ERR state.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NUM_PROGS    = SEQ_NUM_PROGS,
    parameter int unsigned PC_W         = 10,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned START_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 60000,
    localparam int unsigned IDX_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             CoreAck,
    output logic             CoreStart,
    output logic [PC_W-1:0]  CoreStartAddr,
    output logic [IDX_W-1:0] ProgIdx,
    output logic             Busy,
    output logic             AllDone,
    output logic [CNT_W-1:0] CycleCnt,
    output logic             CntValid,
    output logic             TimedOut
);

    localparam int unsigned LW = (START_CYCLES > 1) ? $clog2(START_CYCLES + 1) : 1;

    seq_state_e       state_q, state_d;
    logic             ack_q;
    logic [LW-1:0]    launch_cnt_q;
    logic [IDX_W-1:0] prog_idx_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic             cnt_valid_q;

    logic             ack_rise, run_ack, run_expired, last_prog, launch_last, start_seq;
    logic [CNT_W-1:0] count_next;
    logic             limit_hit;

    // A level-high Ack left over from the previous program never counts.
    assign ack_rise    = CoreAck & ~ack_q;
    assign run_ack     = (state_q == RUN) && ack_rise;
    assign last_prog   = (prog_idx_q == IDX_W'(NUM_PROGS - 1));
    assign launch_last = (launch_cnt_q == LW'(START_CYCLES - 1));
    assign start_seq   = Go && !(state_q inside {LAUNCH, RUN});

`ifdef SEQ_TIMEOUT_EN
    assign run_expired = (state_q == RUN) && !ack_rise && limit_hit;
`else
    logic unused_limit;
    assign unused_limit = limit_hit;
    assign run_expired  = 1'b0;
`endif

    seq_cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_cycle_counter (
        .clk        (Clk),
        .reset      (Reset),
        .clr        (state_q == LAUNCH),
        .en         (state_q == RUN),
        .count_next (count_next),
        .limit_hit  (limit_hit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (Go) state_d = LAUNCH;
            LAUNCH: if (launch_last) state_d = RUN;
            RUN: begin
                if (ack_rise) begin
                    state_d = last_prog ? DONE : LAUNCH;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (run_expired) begin
                    state_d = ERR;
                end
`endif
            end
            DONE:   if (Go) state_d = LAUNCH;
`ifdef SEQ_TIMEOUT_EN
            ERR:    if (Go) state_d = LAUNCH;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        CoreStart = (state_q == LAUNCH) && !Reset;
        Busy      = (state_q inside {LAUNCH, RUN});
        AllDone   = (state_q == DONE);
        TimedOut  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        TimedOut  = (state_q == ERR);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ack_q        <= 1'b0;
            launch_cnt_q <= '0;
            prog_idx_q   <= '0;
            cycle_cnt_q  <= '0;
            cnt_valid_q  <= 1'b0;
        end else begin
            ack_q       <= CoreAck;
            cnt_valid_q <= 1'b0;
            if ((state_q == LAUNCH) && !launch_last) begin
                launch_cnt_q <= launch_cnt_q + LW'(1);
            end else begin
                launch_cnt_q <= '0;
            end
            if (start_seq) begin
                prog_idx_q <= '0;
            end else if (run_ack && !last_prog) begin
                prog_idx_q <= prog_idx_q + IDX_W'(1);
            end
            if (run_ack || run_expired) begin
                cycle_cnt_q <= count_next;
                cnt_valid_q <= 1'b1;
            end
        end
    end

    assign CoreStartAddr = PC_W'(prog_base(32'(prog_idx_q)));
    assign ProgIdx       = prog_idx_q;
    assign CycleCnt      = cycle_cnt_q;
    assign CntValid      = cnt_valid_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a core model acks after chosen RUN-cycle counts,
// expected launches and cycle counts are queued and checked by an independent monitor.
module tb_program_sequencer;

    localparam int NP = 3;
`ifdef SEQ_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 60000;
`endif

    typedef int arr_t [NP];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       core_ack = 1'b0;
    logic       core_start;
    logic [9:0] core_start_addr;
    logic [1:0] prog_idx;
    logic       busy;
    logic       all_done;
    logic [15:0] cycle_cnt;
    logic       cnt_valid;
    logic       timed_out;

    program_sequencer #(
        .NUM_PROGS    (NP),
        .PC_W         (10),
        .CNT_W        (16),
        .START_CYCLES (1),
        .TIMEOUT      (TO)
    ) dut (
        .Clk           (clk),
        .Reset         (reset),
        .Go            (go),
        .CoreAck       (core_ack),
        .CoreStart     (core_start),
        .CoreStartAddr (core_start_addr),
        .ProgIdx       (prog_idx),
        .Busy          (busy),
        .AllDone       (all_done),
        .CycleCnt      (cycle_cnt),
        .CntValid      (cnt_valid),
        .TimedOut      (timed_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_addr_q [$];
    int exp_idx_q [$];
    int exp_cnt_q [$];
    logic prev_start = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT event with nothing expected (t=%0t)", name, $time);
    endtask

    // Monitor: samples on the falling edge, stimulus moves 1 time unit later.
    always @(negedge clk) begin
        if (cnt_valid) begin
            if (exp_cnt_q.size() == 0) unexpected("CntValid");
            else check("CycleCnt", cycle_cnt, exp_cnt_q.pop_front());
        end
        if (core_start && !prev_start) begin
            if (exp_addr_q.size() == 0) begin
                unexpected("CoreStart");
            end else begin
                check("CoreStartAddr", core_start_addr, exp_addr_q.pop_front());
                check("ProgIdx at launch", prog_idx, exp_idx_q.pop_front());
            end
        end
        prev_start = core_start;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // d: RUN cycles until ack; drop: RUN cycle at which an Ack held from the previous
    // program falls (0 = cleared at launch); go_at: RUN cycle with a stray Go pulse;
    // abort_prog/abort_k: Reset during that program (k=0 means during LAUNCH).
    task automatic run_seq(input arr_t d, input arr_t drop, input arr_t go_at,
                           input int abort_prog, input int abort_k);
        for (int i = 0; i < NP; i++) begin
            if (abort_prog < 0 || i <= abort_prog) begin
                exp_addr_q.push_back(i * 128);
                exp_idx_q.push_back(i);
            end
            if (abort_prog < 0 || i < abort_prog) exp_cnt_q.push_back(d[i]);
        end
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < NP; i++) begin
            check("CoreStart at launch", core_start, 1);
            check("Busy at launch", busy, 1);
            if (drop[i] == 0) core_ack = 1'b0;
            if (i == abort_prog && abort_k == 0) begin
                reset = 1'b1;
                #1;
                check("CoreStart dropped by Reset", core_start, 0);
                tick();
                reset = 1'b0;
                core_ack = 1'b0;
                check("Busy after Reset", busy, 0);
                check("ProgIdx after Reset", prog_idx, 0);
                return;
            end
            for (int k = 1; k <= d[i]; k++) begin
                tick();
                if (k == drop[i]) core_ack = 1'b0;
                go = (k == go_at[i]);
                if (i == abort_prog && k == abort_k) begin
                    reset = 1'b1;
                    go = 1'b0;
                    tick();
                    reset = 1'b0;
                    core_ack = 1'b0;
                    check("CoreStart after Reset", core_start, 0);
                    check("Busy after Reset", busy, 0);
                    check("ProgIdx after Reset", prog_idx, 0);
                    check("AllDone after Reset", all_done, 0);
                    return;
                end
                if (k == d[i]) core_ack = 1'b1;
                else check("Busy in RUN", busy, 1);
            end
            tick();
            go = 1'b0;
        end
        check("AllDone after last ack", all_done, 1);
        check("Busy in DONE", busy, 0);
        check("CoreStart in DONE", core_start, 0);
        check("ProgIdx in DONE", prog_idx, NP - 1);
        check("TimedOut in DONE", timed_out, 0);
        core_ack = 1'b0;
        tick();
        check("AllDone held", all_done, 1);
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic run_timeout();
        exp_addr_q.push_back(0);
        exp_idx_q.push_back(0);
        exp_cnt_q.push_back(TO);
        core_ack = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("CoreStart before timeout", core_start, 1);
        repeat (TO) tick();
        check("Busy on last RUN cycle", busy, 1);
        tick();
        check("TimedOut", timed_out, 1);
        check("Busy in ERR", busy, 0);
        check("AllDone in ERR", all_done, 0);
        check("CycleCnt in ERR", cycle_cnt, TO);
        repeat (3) tick();
        check("TimedOut held", timed_out, 1);
        exp_addr_q.push_back(0);
        exp_idx_q.push_back(0);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("TimedOut cleared by Go", timed_out, 0);
        check("CoreStart after ERR restart", core_start, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
`endif

    initial begin
        arr_t d, drop, go_at;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("reset CoreStart", core_start, 0);
            check("reset Busy", busy, 0);
            check("reset AllDone", all_done, 0);
            check("reset CntValid", cnt_valid, 0);
            check("reset TimedOut", timed_out, 0);
            check("reset ProgIdx", prog_idx, 0);
            check("reset CoreStartAddr", core_start_addr, 0);
            check("reset CycleCnt", cycle_cnt, 0);
        end
        reset = 1'b0;
        tick();

        run_seq('{20, 35, 50}, '{0, 0, 0}, '{0, 0, 0}, -1, 0);
        run_seq('{10, 15, 12}, '{0, 5, 0}, '{0, 0, 0}, -1, 0);
        run_seq('{8, 12, 9}, '{0, 0, 0}, '{0, 4, 0}, -1, 0);
        run_seq('{6, 7, 9}, '{0, 0, 0}, '{0, 0, 9}, -1, 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NP; i++) begin
                d[i] = int'($urandom_range(2, 40));
                drop[i] = 0;
                if (i > 0 && d[i] >= 3 && $urandom_range(0, 1) == 1)
                    drop[i] = int'($urandom_range(1, d[i] - 1));
                go_at[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, d[i])) : 0;
            end
            run_seq(d, drop, go_at, -1, 0);
        end

        run_seq('{9, 20, 9}, '{0, 0, 0}, '{0, 0, 0}, 1, 5);
        tick();
        run_seq('{9, 20, 9}, '{0, 0, 0}, '{0, 0, 0}, 1, 0);
        tick();
        run_seq('{3, 4, 5}, '{0, 0, 0}, '{0, 0, 0}, -1, 0);

`ifdef SEQ_TIMEOUT_EN
        tick();
        run_timeout();
`endif

        repeat (3) tick();
        check("pending launches", exp_addr_q.size(), 0);
        check("pending counts", exp_cnt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
